prio_encoder_hs: RTL

Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes on input and output.
- Generalises the team's 4:2 combinational encoder to any width N.
- Reports a "found" flag and the population count of the request vector.
- Supports fixed-priority or round-robin selection.
- Sits between request-collection logic and downstream arbitration/dispatch, decoupling them by one register stage.

---
 rtl/prio_enc_pkg.sv | 24 ++
 rtl/prio_find.sv | 26 ++
 rtl/prio_encoder_hs.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared definitions for the handshaked priority encoder.
//   MODE_FIXED / MODE_RR : selection-mode constants for prio_encoder_hs.
//   MAX_N                : widest request vector the encoder supports.
//   popcount()           : counts set bits in the low 'width' bits of a
//                          vector zero-extended to MAX_N bits.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_N      = 64;

  // Only the lowest 'width' bits are counted, so a caller can pass a
  // narrower vector zero-extended to MAX_N without any stray bits counting.
  function automatic logic [6:0] popcount(input logic [MAX_N-1:0] vec,
                                          input int               width);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < width && vec[i]) cnt = cnt + 7'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational highest-set-bit finder.
//   vec   in  N   vector to scan
//   idx   out IW  index of the highest set bit (0 when none is set)
//   found out 1   at least one bit of vec is set
module prio_find #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan upward so that the last set bit seen, the highest one, wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: registered N-to-log2(N) priority encoder with valid/ready
// handshakes on both sides, one register stage of latency.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; req is sampled on the transfer edge
//   req[N-1:0]          request vector
//   out_valid/out_ready output handshake
//   out_idx[IW-1:0]     selected line
//   out_found           at least one request was set
//   out_cnt[CW-1:0]     popcount of the accepted request vector
// Optional (macro PRIO_ENC_MULTIHOT_ERR_EN):
//   err_clr   in   clear the sticky multi-hot flag on the next edge
//   err_multi out  sticky flag, set when an accepted req has >1 bit set
// MODE selects fixed priority (highest index wins) or round-robin.
module prio_encoder_hs
  import prio_enc_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int MODE = MODE_FIXED,
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_found,
  output logic [CW-1:0] out_cnt
`ifdef PRIO_ENC_MULTIHOT_ERR_EN
  ,
  input  logic          err_clr,
  output logic          err_multi
`endif
);

  logic             in_xfer;
  logic             out_xfer;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic [CW-1:0]    sel_cnt;
  logic [MAX_N-1:0] req_ext;

  // No skid buffer: a new vector is taken only when the result register is
  // empty or being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign sel_cnt = CW'(popcount(req_ext, N));

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [IW-1:0] ptr;
      logic [IW-1:0] src;
      logic [N-1:0]  scan_vec;
      logic [IW-1:0] scan_idx;
      logic          scan_found;

      // Rotate req so that line ptr lands on the top bit and later lines
      // follow downward; the highest-bit finder then picks the first set
      // line met when scanning upward from ptr with wrap-around.
      always_comb begin
        src      = '0;
        scan_vec = '0;
        for (int k = 0; k < N; k++) begin
          src         = IW'((int'(ptr) + N - 1 - k) % N);
          scan_vec[k] = req[src];
        end
      end

      prio_find #(.N(N)) u_find (
        .vec   (scan_vec),
        .idx   (scan_idx),
        .found (scan_found)
      );

      assign sel_found = scan_found;
      assign sel_idx   = scan_found ?
                         IW'((int'(ptr) + N - 1 - int'(scan_idx)) % N) : '0;

      // Move the pointer just past the winner so it gets lowest priority
      // next time; empty transfers leave the pointer where it is.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr <= '0;
        end else if (in_xfer && sel_found) begin
          ptr <= (sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1);
        end
      end
    end else begin : g_fixed
      prio_find #(.N(N)) u_find (
        .vec   (req),
        .idx   (sel_idx),
        .found (sel_found)
      );
    end
  endgenerate

  // Result register: an input transfer always loads a fresh result, which
  // also covers the simultaneous input/output case; a lone output transfer
  // just empties the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_found <= 1'b0;
      out_cnt   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_idx   <= sel_idx;
      out_found <= sel_found;
      out_cnt   <= sel_cnt;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PRIO_ENC_MULTIHOT_ERR_EN
  // Sticky multi-hot flag; a new offending transfer beats a clear request
  // in the same cycle so no violation is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_multi <= 1'b0;
    end else if (in_xfer && (sel_cnt > CW'(1))) begin
      err_multi <= 1'b1;
    end else if (err_clr) begin
      err_multi <= 1'b0;
    end
  end
`endif

endmodule
